alu_iq_gen: RTL

- Parametrised issue queue for integer/branch FUs; successor to the fixed 4-entry ALU IQ.
- Sits between rename/dispatch and one FU pipeline.
- Accepts up to DISPATCH_W uops per cycle, tracks two source operands per entry and captures operands from CDB_W result broadcast channels.
- Issues the oldest fully-ready entry into a registered output stage, with a valid/ready handshake toward the FU.

---
 rtl/alu_iq_gen.sv | 197 +++++++++++++++++++
 1 files changed

// File: rtl/alu_iq_gen.sv
// Parametrised integer/branch issue queue: dispatch with same-cycle CDB capture,
// per-source wakeup, age-matrix oldest-ready select and a registered issue stage.
module alu_iq_gen #(
  parameter int IQ_DEPTH   = 8,
  parameter int DISPATCH_W = 2,
  parameter int CDB_W      = 2,
  parameter int TAG_W      = 6,
  parameter int DATA_W     = 32,
  parameter int PAYLOAD_W  = 64
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              flush_i,
  input  logic [DISPATCH_W-1:0]             disp_valid_i,
  input  logic [DISPATCH_W*PAYLOAD_W-1:0]   disp_payload_i,
  input  logic [DISPATCH_W*2*TAG_W-1:0]     disp_src_tag_i,
  input  logic [DISPATCH_W*2-1:0]           disp_src_rdy_i,
  input  logic [DISPATCH_W*2*DATA_W-1:0]    disp_src_data_i,
  output logic                              disp_ready_o,
  input  logic [CDB_W-1:0]                  cdb_valid_i,
  input  logic [CDB_W*TAG_W-1:0]            cdb_tag_i,
  input  logic [CDB_W*DATA_W-1:0]           cdb_data_i,
  output logic                              issue_valid_o,
  input  logic                              issue_ready_i,
  output logic [PAYLOAD_W-1:0]              issue_payload_o,
  output logic [2*DATA_W-1:0]               issue_src_data_o,
  output logic [$clog2(IQ_DEPTH+1)-1:0]     free_cnt_o
);

  localparam int CNT_W = $clog2(IQ_DEPTH + 1);
  localparam int IDX_W = $clog2(IQ_DEPTH);

  logic [IQ_DEPTH-1:0]  valid_q, valid_d;
  logic [IQ_DEPTH-1:0]  older_q [IQ_DEPTH];
  logic [IQ_DEPTH-1:0]  older_d [IQ_DEPTH];
  logic [1:0]           rdy_q [IQ_DEPTH];
  logic [1:0]           rdy_d [IQ_DEPTH];
  logic [TAG_W-1:0]     tag_q [IQ_DEPTH][2];
  logic [TAG_W-1:0]     tag_d [IQ_DEPTH][2];
  logic [DATA_W-1:0]    data_q [IQ_DEPTH][2];
  logic [DATA_W-1:0]    data_d [IQ_DEPTH][2];
  logic [PAYLOAD_W-1:0] payload_q [IQ_DEPTH];
  logic [PAYLOAD_W-1:0] payload_d [IQ_DEPTH];
  logic [CNT_W-1:0]     free_cnt_q, free_cnt_d;

  logic                 issue_valid_q;
  logic [PAYLOAD_W-1:0] issue_payload_q;
  logic [2*DATA_W-1:0]  issue_data_q;

  logic [IQ_DEPTH-1:0]  eligible, sel_oh;
  logic [IDX_W-1:0]     sel_idx;
  logic                 any_eligible, advance, do_issue, disp_ready;

  // Returns {hit, data}; channels scanned high to low so the lowest index wins.
  function automatic logic [DATA_W:0] cdb_lookup(input logic [TAG_W-1:0] tag);
    logic [DATA_W:0] r;
    r = '0;
    for (int c = CDB_W - 1; c >= 0; c--) begin
      if (cdb_valid_i[c] && cdb_tag_i[c*TAG_W +: TAG_W] == tag)
        r = {1'b1, cdb_data_i[c*DATA_W +: DATA_W]};
    end
    return r;
  endfunction

  assign disp_ready   = free_cnt_q >= CNT_W'(DISPATCH_W);
  assign any_eligible = |eligible;
  assign advance      = !issue_valid_q || issue_ready_i;
  assign do_issue     = advance && any_eligible;

  // The age matrix is a total order over valid entries, so exactly one eligible
  // entry has no older eligible entry.
  always_comb begin
    // NOTE: every combinational output gets a default first so no path can infer a latch.
    eligible = '0;
    sel_oh   = '0;
    sel_idx  = '0;
    for (int i = 0; i < IQ_DEPTH; i++)
      eligible[i] = valid_q[i] && rdy_q[i][0] && rdy_q[i][1];
    for (int i = 0; i < IQ_DEPTH; i++) begin
      sel_oh[i] = eligible[i];
      for (int j = 0; j < IQ_DEPTH; j++)
        if (j != i && eligible[j] && older_q[j][i]) sel_oh[i] = 1'b0;
    end
    for (int i = 0; i < IQ_DEPTH; i++)
      if (sel_oh[i]) sel_idx = IDX_W'(i);
  end

  always_comb begin
    logic [IQ_DEPTH-1:0] taken;
    logic [CNT_W-1:0]    n_acc;
    logic [DATA_W:0]     hit;
    logic                found;
    valid_d   = valid_q;
    older_d   = older_q;
    rdy_d     = rdy_q;
    tag_d     = tag_q;
    data_d    = data_q;
    payload_d = payload_q;
    taken     = '0;
    n_acc     = '0;
    hit       = '0;
    found     = 1'b0;

    for (int i = 0; i < IQ_DEPTH; i++)
      for (int k = 0; k < 2; k++)
        if (valid_q[i] && !rdy_q[i][k]) begin
          hit = cdb_lookup(tag_q[i][k]);
          if (hit[DATA_W]) begin
            rdy_d[i][k]  = 1'b1;
            data_d[i][k] = hit[DATA_W-1:0];
          end
        end

    for (int e = 0; e < IQ_DEPTH; e++)
      if (do_issue && sel_oh[e]) begin
        valid_d[e] = 1'b0;
        older_d[e] = '0;
        for (int r = 0; r < IQ_DEPTH; r++) older_d[r][e] = 1'b0;
      end

    // Allocation only looks at registered validity: an entry freed this cycle
    // becomes reusable next cycle.
    for (int s = 0; s < DISPATCH_W; s++)
      if (disp_ready && disp_valid_i[s]) begin
        found = 1'b0;
        for (int i = 0; i < IQ_DEPTH; i++)
          if (!found && !valid_q[i] && !taken[i]) begin
            found        = 1'b1;
            valid_d[i]   = 1'b1;
            payload_d[i] = disp_payload_i[s*PAYLOAD_W +: PAYLOAD_W];
            for (int k = 0; k < 2; k++) begin
              tag_d[i][k] = disp_src_tag_i[(s*2+k)*TAG_W +: TAG_W];
              if (disp_src_rdy_i[s*2+k]) begin
                rdy_d[i][k]  = 1'b1;
                data_d[i][k] = disp_src_data_i[(s*2+k)*DATA_W +: DATA_W];
              end else begin
                hit          = cdb_lookup(tag_d[i][k]);
                rdy_d[i][k]  = hit[DATA_W];
                data_d[i][k] = hit[DATA_W-1:0];
              end
            end
            older_d[i] = '0;
            for (int e = 0; e < IQ_DEPTH; e++)
              older_d[e][i] = (valid_q[e] && !(do_issue && sel_oh[e])) || taken[e];
            taken[i] = 1'b1;
            n_acc    = n_acc + CNT_W'(1);
          end
      end

    free_cnt_d = free_cnt_q - n_acc + CNT_W'(do_issue);
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q         <= '0;
      for (int i = 0; i < IQ_DEPTH; i++) older_q[i] <= '0;
      free_cnt_q      <= CNT_W'(IQ_DEPTH);
      issue_valid_q   <= 1'b0;
      issue_payload_q <= '0;
      issue_data_q    <= '0;
    end else if (flush_i) begin
      valid_q         <= '0;
      for (int i = 0; i < IQ_DEPTH; i++) older_q[i] <= '0;
      free_cnt_q      <= CNT_W'(IQ_DEPTH);
      issue_valid_q   <= 1'b0;
      issue_payload_q <= '0;
      issue_data_q    <= '0;
    end else begin
      valid_q    <= valid_d;
      older_q    <= older_d;
      free_cnt_q <= free_cnt_d;
      if (advance) begin
        issue_valid_q <= any_eligible;
        if (any_eligible) begin
          issue_payload_q <= payload_q[sel_idx];
          issue_data_q    <= {data_q[sel_idx][1], data_q[sel_idx][0]};
        end
      end
    end
  end

  // NOTE: entry storage has no reset; it is only observed through valid_q.
  always_ff @(posedge clk) begin
    rdy_q     <= rdy_d;
    tag_q     <= tag_d;
    data_q    <= data_d;
    payload_q <= payload_d;
  end

  assign disp_ready_o     = disp_ready;
  assign issue_valid_o    = issue_valid_q;
  assign issue_payload_o  = issue_payload_q;
  assign issue_src_data_o = issue_data_q;
  assign free_cnt_o       = free_cnt_q;

endmodule
